// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - control-unit state register and next-state selection
// Bounded memory wait and illegal-opcode trap both return to fetch state 0.
module microsequencer #(
  parameter int MAX_STATE  = 36,
  parameter int WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ns_sel,
  input  logic [6:0] cr_addr,
  input  logic       inv,
  input  logic [1:0] cond_sel,
  input  logic       moc,
  input  logic       zero,
  input  logic       br_cond,
  input  logic [6:0] enc_state,
  input  logic       enc_valid,
  output logic [6:0] current_state,
  output logic [7:0] wait_cnt,
  output logic       timeout_err,
  output logic       illegal_op
);

  typedef enum logic [2:0] {
    NS_DISPATCH = 3'b000,
    NS_FETCH    = 3'b001,
    NS_INC      = 3'b010,
    NS_JUMP     = 3'b011,
    NS_CBR_INC  = 3'b100,
    NS_CBR_DISP = 3'b101,
    NS_WAIT     = 3'b110,
    NS_RSVD     = 3'b111
  } ns_mode_t;

  localparam logic [6:0] MAX_S     = 7'(MAX_STATE);
  localparam logic [7:0] WAIT_SAT  = 8'(WAIT_LIMIT);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  ns_mode_t   mode;
  logic       cond_raw;
  logic       c;
  logic [6:0] inc;
  logic [6:0] disp_state;
  logic       disp_illegal;
  logic [6:0] sel_state;
  logic [6:0] next_state;
  logic       hold;
  logic       timeout_next;
  logic       illegal_next;
  logic [7:0] wait_cnt_next;

  always_comb begin
    cond_raw      = 1'b1;
    c             = 1'b0;
    inc           = current_state + 7'd1;
    disp_state    = 7'd0;
    disp_illegal  = 1'b0;
    sel_state     = 7'd0;
    next_state    = 7'd0;
    hold          = 1'b0;
    timeout_next  = 1'b0;
    illegal_next  = 1'b0;
    wait_cnt_next = 8'd0;
    mode          = ns_mode_t'(ns_sel);

    case (cond_sel)
      2'b00:   cond_raw = moc;
      2'b01:   cond_raw = zero;
      2'b10:   cond_raw = br_cond;
      default: cond_raw = 1'b1;
    endcase
    c = cond_raw ^ inv;

    if (enc_valid) begin
      disp_state = enc_state;
    end else begin
      disp_illegal = 1'b1;
    end

    case (mode)
      NS_DISPATCH: begin
        sel_state    = disp_state;
        illegal_next = disp_illegal;
      end
      NS_FETCH:   sel_state = 7'd0;
      NS_INC:     sel_state = inc;
      NS_JUMP:    sel_state = cr_addr;
      NS_CBR_INC: sel_state = c ? cr_addr : inc;
      NS_CBR_DISP: begin
        if (c) begin
          sel_state = cr_addr;
        end else begin
          sel_state    = disp_state;
          illegal_next = disp_illegal;
        end
      end
      NS_WAIT: begin
        // A satisfied condition takes priority over an expiring wait.
        if (c) begin
          sel_state = inc;
        end else if (wait_cnt == WAIT_LAST) begin
          sel_state    = 7'd0;
          timeout_next = 1'b1;
        end else begin
          sel_state = current_state;
          hold      = 1'b1;
        end
      end
      default: sel_state = 7'd0;
    endcase

    next_state = (sel_state > MAX_S) ? 7'd0 : sel_state;

    if (hold) begin
      wait_cnt_next = (wait_cnt == WAIT_SAT) ? wait_cnt : wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      current_state <= 7'd0;
      wait_cnt      <= 8'd0;
      timeout_err   <= 1'b0;
      illegal_op    <= 1'b0;
    end else begin
      current_state <= next_state;
      wait_cnt      <= wait_cnt_next;
      timeout_err   <= timeout_next;
      illegal_op    <= illegal_next;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// tb/tb_microsequencer.sv - randomized and directed check of microsequencer against a reference model
module tb_microsequencer;
  localparam int MAX_STATE  = 36;
  localparam int WAIT_LIMIT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] ns_sel;
  logic [6:0] cr_addr;
  logic       inv;
  logic [1:0] cond_sel;
  logic       moc;
  logic       zero;
  logic       br_cond;
  logic [6:0] enc_state;
  logic       enc_valid;
  logic [6:0] current_state;
  logic [7:0] wait_cnt;
  logic       timeout_err;
  logic       illegal_op;

  int n_checks = 0;
  int n_pass   = 0;

  int m_state = 0;
  int m_wait  = 0;
  int m_tout  = 0;
  int m_ill   = 0;

  microsequencer #(.MAX_STATE(MAX_STATE), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .reset(reset), .ns_sel(ns_sel), .cr_addr(cr_addr), .inv(inv),
    .cond_sel(cond_sel), .moc(moc), .zero(zero), .br_cond(br_cond),
    .enc_state(enc_state), .enc_valid(enc_valid), .current_state(current_state),
    .wait_cnt(wait_cnt), .timeout_err(timeout_err), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: one microword step computed from the sequencing rules.
  task automatic model_step();
    int cond, c, inc, nxt, disp, disp_bad, holding;
    if (reset) begin
      m_state = 0; m_wait = 0; m_tout = 0; m_ill = 0;
      return;
    end
    cond = (cond_sel == 0) ? moc : (cond_sel == 1) ? zero : (cond_sel == 2) ? br_cond : 1;
    c = (cond != 0) != (inv != 0);
    inc = (m_state + 1) % 128;
    disp = enc_valid ? int'(enc_state) : 0;
    disp_bad = !enc_valid;
    holding = 0;
    m_tout = 0;
    m_ill = 0;
    case (int'(ns_sel))
      0: begin nxt = disp; m_ill = disp_bad; end
      1: nxt = 0;
      2: nxt = inc;
      3: nxt = cr_addr;
      4: nxt = c ? int'(cr_addr) : inc;
      5: if (c) nxt = cr_addr; else begin nxt = disp; m_ill = disp_bad; end
      6: if (c) nxt = inc;
         else if (m_wait == WAIT_LIMIT - 1) begin nxt = 0; m_tout = 1; end
         else begin nxt = m_state; holding = 1; end
      default: nxt = 0;
    endcase
    if (nxt > MAX_STATE) nxt = 0;
    m_state = nxt;
    m_wait = holding ? ((m_wait + 1 > WAIT_LIMIT) ? WAIT_LIMIT : m_wait + 1) : 0;
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".state"}, current_state, m_state);
    check({tag, ".wait_cnt"}, wait_cnt, m_wait);
    check({tag, ".timeout_err"}, timeout_err, m_tout);
    check({tag, ".illegal_op"}, illegal_op, m_ill);
  endtask

  task automatic word(input int ns, input int cr, input int cs, input int iv);
    reset = 1'b0; ns_sel = 3'(ns); cr_addr = 7'(cr); cond_sel = 2'(cs); inv = iv[0];
  endtask

  initial begin
    reset = 1'b1; ns_sel = 3'b011; cr_addr = 7'd5; inv = 1'b0; cond_sel = 2'b00;
    moc = 1'b0; zero = 1'b0; br_cond = 1'b0; enc_state = 7'd0; enc_valid = 1'b1;

    step("reset0");
    step("reset1");
    check("reset_state_const", current_state, 0);
    word(3, 5, 0, 0); step("release");
    check("release_jump_const", current_state, 5);

    word(3, 1, 0, 0); step("to1");
    word(6, 0, 0, 0); moc = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step("hold");
      check("hold_cnt_const", wait_cnt, i);
    end
    moc = 1'b1; step("moc_done");
    check("wait_exit_const", current_state, 2);

    word(3, 1, 0, 0); step("to1b");
    word(6, 0, 0, 0); moc = 1'b0;
    for (int i = 0; i < 4; i++) step("tout_hold");
    check("timeout_state_const", current_state, 0);
    check("timeout_pulse_const", timeout_err, 1);
    word(1, 0, 0, 0); step("tout_clear");
    check("timeout_clear_const", timeout_err, 0);

    word(3, 1, 0, 0); step("to1c");
    word(6, 0, 0, 0); moc = 1'b0;
    for (int i = 0; i < 3; i++) step("race_hold");
    moc = 1'b1; step("race_c_wins");
    check("race_state_const", current_state, 2);

    word(3, 9, 0, 0); step("to9");
    word(4, 20, 1, 1); zero = 1'b1; step("cbr_inv");
    check("cbr_inv_const", current_state, 10);
    word(3, 9, 0, 0); step("to9b");
    word(4, 20, 1, 0); step("cbr_take");
    check("cbr_take_const", current_state, 20);

    word(0, 0, 0, 0); enc_valid = 1'b0; enc_state = 7'd17; step("disp_bad");
    check("illegal_const", illegal_op, 1);
    enc_valid = 1'b1; step("disp_ok");
    check("dispatch_const", current_state, 17);

    word(3, 100, 0, 0); step("clamp_jump");
    word(7, 5, 0, 0); step("reserved");
    word(3, 36, 0, 0); step("to36");
    word(2, 0, 0, 0); step("inc36");
    check("inc36_const", current_state, 0);

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 59) == 0);
      ns_sel    = ($urandom_range(0, 3) == 0) ? 3'b110 : 3'($urandom);
      cr_addr   = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 40));
      inv       = 1'($urandom);
      cond_sel  = 2'($urandom);
      moc       = ($urandom_range(0, 4) == 0);
      zero      = 1'($urandom);
      br_cond   = 1'($urandom);
      enc_state = 7'($urandom_range(0, 63));
      enc_valid = ($urandom_range(0, 5) != 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
